pipe_flush_ctrl: RTL
====================

Name: pipe_flush_ctrl

Overview:
Parametrised pipeline control-bundle carrier with integrated flush/discard sequencing. It accepts the decoded control bundle from ID and shifts it through NSTAGE downstream stage registers (EX, MEM, WB, ...). It inserts bubbles on stall or flush, and generates IF/ID flush strobes for configurable multi-cycle branch/jump penalty windows. It replaces per-signal AND-gating and single-cycle discard logic with one sequential block sized by parameters.

Parameters:
CTRL_W, 10, width of control bundle (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, JRControl, ALUOp[1:0])
NSTAGE, 3, number of downstream stage registers carrying the bundle (index 0 = EX)
BR_PENALTY, 1, cycles IF+ID are flushed after taken branch (bne) or jr, 1..15
JMP_PENALTY, 1, cycles IF alone is flushed after jump, 1..15

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
id_ctrl  input  CTRL_W  decoded control bundle of instruction in ID
id_valid  input  1  ID holds a real instruction
stall  input  1  load-use stall: bubble into stage 0, hold IF/ID (holding is external)
jump  input  1  jump resolved in ID this cycle
bne  input  1  branch resolved taken this cycle
jr  input  1  jump-register resolved this cycle
stage_ctrl  output  NSTAGE*CTRL_W  registered bundles, stage k at bits [k*CTRL_W +: CTRL_W]
stage_valid  output  NSTAGE  per-stage valid
if_flush  output  1  discard instruction entering IF/ID
id_flush  output  1  discard instruction in ID (zero its bundle)
flush_busy  output  1  penalty window active beyond event cycle
flush_count  output  16  bubbles inserted (see optional feature)

Behaviour:
- Reset (sync, high): all stage_ctrl = 0, stage_valid = 0, window counter cnt = 0, mode = NONE, flush_count = 0. if_flush/id_flush = 0 during reset regardless of inputs.
- redirect = bne | jr. Event priority: reset > redirect > jump > stall.
- Window: 4-bit cnt, 1-bit mode (BR/JMP).
  - On redirect: cnt <= BR_PENALTY-1, mode <= BR.
  - Else on jump: cnt <= JMP_PENALTY-1, mode <= JMP.
  - Else if cnt != 0: cnt <= cnt-1.
  - A new event during an active window always reloads cnt and overwrites mode (no accumulation).
  - When cnt is 0, mode is don't-care.
- Flush outputs (combinational from inputs and registered state):
  - if_flush = redirect | jump | (cnt != 0).
  - id_flush = redirect | (cnt != 0 & mode == BR).
  - flush_busy = (cnt != 0).
  - With penalty 1 this reduces exactly to the single-cycle discard rule: IF on jump/bne/jr, ID on bne/jr.
- Stage 0 update each cycle:
  - If stall | id_flush | !id_valid: stage_ctrl[0] <= 0, stage_valid[0] <= 0 (bubble).
  - Otherwise stage_ctrl[0] <= id_ctrl, stage_valid[0] <= 1.
  - Latency ID to stage 0 is 1 cycle.
- Stage k>0: unconditionally takes stage k-1 each cycle. Stall does not freeze downstream stages; a bundle reaches stage k after k+1 cycles.
- Invariant: stage_valid[k] == 0 implies stage_ctrl[k] == 0 (no leaking control on bubbles).
- Simultaneous stall + redirect: one bubble, counted once. Redirect still loads cnt.
- Reset mid-window: cnt cleared, flushes deassert the same cycle reset is high, all stages emptied.

Optional Feature:
FLUSH_STATS_EN
- Defined: flush_count increments by 1 each cycle a bubble is inserted into stage 0 due to stall or id_flush while id_valid = 1. Saturates at 16'hFFFF. Cleared by reset.
- Undefined: no counter logic; flush_count tied to 0.

Test Plan:
- Reset then id_valid=1, id_ctrl=10'h2A5 for 1 cycle, no events → stage_ctrl[0]=10'h2A5 with valid on cycle+1; appears in stage 1 at +2 and stage 2 at +3. All other slots 0 with valid 0.
- Defaults, pulse bne with id_ctrl=10'h3FF → if_flush=id_flush=1 that cycle only; stage 0 gets a bubble; flush_busy stays 0.
- BR_PENALTY=3, pulse jr → if_flush and id_flush high for 3 consecutive cycles; flush_busy high for cycles 2-3; 3 bubbles in stage 0 even with id_valid=1.
- JMP_PENALTY=2, pulse jump → if_flush high for 2 cycles, id_flush stays 0, ID bundle 10'h155 enters stage 0 normally. Then jump at cycle 0 with bne at cycle 1 → mode switches to BR, cnt reloads.
- stall=1 for 2 cycles with id_valid=1 → two bubbles in stage 0 while older bundles keep draining to WB. With FLUSH_STATS_EN, flush_count=2.
- Assert reset while cnt=2 (BR_PENALTY=3) → flushes low during reset, stage_valid=0, cnt=0. After release, no residual flush.

Source files
------------

// File: rtl/pipe_flush_ctrl_if.sv
// Interface bundling the ID-side inputs and stage/flush outputs of
// pipe_flush_ctrl. The master side (decode stage or bench) drives the
// control bundle and redirect events. The slave side (the controller)
// returns the staged bundles and the flush strobes.
interface pipe_flush_ctrl_if #(
    parameter int CTRL_W = 10,
    parameter int NSTAGE = 3
);
    logic [CTRL_W-1:0]        id_ctrl;
    logic                     id_valid;
    logic                     stall;
    logic                     jump;
    logic                     bne;
    logic                     jr;
    logic [NSTAGE*CTRL_W-1:0] stage_ctrl;
    logic [NSTAGE-1:0]        stage_valid;
    logic                     if_flush;
    logic                     id_flush;
    logic                     flush_busy;
    logic [15:0]              flush_count;

    modport master (
        output id_ctrl, id_valid, stall, jump, bne, jr,
        input  stage_ctrl, stage_valid, if_flush, id_flush, flush_busy, flush_count
    );

    modport slave (
        input  id_ctrl, id_valid, stall, jump, bne, jr,
        output stage_ctrl, stage_valid, if_flush, id_flush, flush_busy, flush_count
    );
endinterface

// File: rtl/pipe_flush_ctrl.sv
// pipe_flush_ctrl: carries the decoded control bundle from ID through NSTAGE
// downstream stage registers. It inserts bubbles on stall or ID flush, and it
// drives IF/ID discard strobes over multi-cycle branch/jump penalty windows.
// Optional feature macro: FLUSH_STATS_EN enables a saturating 16-bit count of
// bubbles that displaced a valid ID instruction. Without the macro,
// flush_count is tied to zero.
module pipe_flush_ctrl #(
    parameter int CTRL_W      = 10,
    parameter int NSTAGE      = 3,
    parameter int BR_PENALTY  = 1,
    parameter int JMP_PENALTY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_flush_ctrl_if.slave     bus
);
    typedef enum logic {
        MODE_JMP = 1'b0,
        MODE_BR  = 1'b1
    } mode_t;

    // The counter holds the window cycles remaining after the event cycle.
    // The event cycle itself is covered combinationally by the event inputs.
    localparam logic [3:0] BR_LOAD  = 4'(BR_PENALTY - 1);
    localparam logic [3:0] JMP_LOAD = 4'(JMP_PENALTY - 1);

    logic [3:0]        cnt_reg;
    mode_t             mode_reg;
    logic [CTRL_W-1:0] ctrl_reg [NSTAGE];
    logic [NSTAGE-1:0] valid_reg;

    logic redirect;
    logic window_active;
    logic if_flush_int;
    logic id_flush_int;
    logic bubble;

    assign redirect      = bus.bne | bus.jr;
    assign window_active = (cnt_reg != 4'd0);

    // Flush strobes are suppressed while reset is high, so a window cut short
    // by reset never discards anything in that cycle.
    assign if_flush_int = !reset & (redirect | bus.jump | window_active);
    assign id_flush_int = !reset & (redirect | (window_active & (mode_reg == MODE_BR)));
    assign bubble       = bus.stall | id_flush_int | !bus.id_valid;

    assign bus.if_flush   = if_flush_int;
    assign bus.id_flush   = id_flush_int;
    assign bus.flush_busy = window_active;

    // Penalty window sequencer. A redirect takes priority over a jump. A new
    // event reloads the window rather than extending it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg  <= 4'd0;
            mode_reg <= MODE_JMP;
        end else if (redirect) begin
            cnt_reg  <= BR_LOAD;
            mode_reg <= MODE_BR;
        end else if (bus.jump) begin
            cnt_reg  <= JMP_LOAD;
            mode_reg <= MODE_JMP;
        end else if (window_active) begin
            cnt_reg  <= cnt_reg - 4'd1;
        end
    end

    // Stage shift register. Stage 0 takes either the ID bundle or a zeroed
    // bubble. Later stages always advance, so a stall drains older bundles.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                ctrl_reg[k] <= '0;
            end
            valid_reg <= '0;
        end else begin
            if (bubble) begin
                ctrl_reg[0]  <= '0;
                valid_reg[0] <= 1'b0;
            end else begin
                ctrl_reg[0]  <= bus.id_ctrl;
                valid_reg[0] <= 1'b1;
            end
            for (int k = 1; k < NSTAGE; k++) begin
                ctrl_reg[k]  <= ctrl_reg[k-1];
                valid_reg[k] <= valid_reg[k-1];
            end
        end
    end

    // Flatten the per-stage bundles onto the packed output bus.
    generate
        for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage_out
            assign bus.stage_ctrl[gi*CTRL_W +: CTRL_W] = ctrl_reg[gi];
        end
    endgenerate

    assign bus.stage_valid = valid_reg;

`ifdef FLUSH_STATS_EN
    logic [15:0] count_reg;

    // Count bubbles that displaced a real instruction, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= 16'd0;
        end else if (bus.id_valid && (bus.stall || id_flush_int) && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign bus.flush_count = count_reg;
`else
    assign bus.flush_count = 16'd0;
`endif
endmodule
